pc_sequencer: RTL

Multi-cycle control FSM that sequences the program counter and execute datapath of the embedded processor. Fetches one instruction word per instruction from program memory, decodes it, and issues single-cycle strobes: PC increment, PC relative branch with offset, register write, and ALU operation select. Sits between program memory, the PC (increment/relative-branch adder with active-low async reset) and the register file/ALU.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC control FSM that drives the
//               program-counter strobes, register-file write enable and
//               ALU operation select of the embedded processor.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PSIZE = 5,
  parameter int ISIZE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ISIZE-1:0] instr,
  input  logic             instr_valid,
  input  logic             zflag,
  output logic             pc_incr,
  output logic             pc_relbranch,
  output logic [PSIZE-1:0] branch_addr,
  output logic             reg_we,
  output logic [1:0]       alu_op,
  output logic [ISIZE-4:0] imm,
  output logic             busy,
  output logic             halted,
  output logic [7:0]       icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] C_OP_NOP  = 3'b000;
  localparam logic [2:0] C_OP_LDI  = 3'b001;
  localparam logic [2:0] C_OP_ADD  = 3'b010;
  localparam logic [2:0] C_OP_SUB  = 3'b011;
  localparam logic [2:0] C_OP_BRZ  = 3'b100;
  localparam logic [2:0] C_OP_BRA  = 3'b101;
  localparam logic [2:0] C_OP_RSV  = 3'b110;
  localparam logic [2:0] C_OP_HALT = 3'b111;

  state_t           state_q, state_d;
  logic [ISIZE-1:0] ir_q, ir_d;
  logic             z_q, z_d;
  logic [7:0]       icount_q, icount_d;

  logic [2:0]       w_opcode;
  logic [ISIZE-4:0] w_field;

  assign w_opcode = ir_q[ISIZE-1:ISIZE-3];
  assign w_field  = ir_q[ISIZE-4:0];

  // State, instruction, latched zero flag and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      z_q      <= 1'b0;
      icount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      icount_q <= icount_d;
    end
  end

  // Next-state logic: IR loads only on a valid FETCH, the zero flag is
  // captured at the end of DECODE, and every EXEC retires one instruction.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    z_d      = z_q;
    icount_d = icount_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        z_d     = zflag;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        icount_d = icount_q + 8'd1;
        state_d  = (w_opcode == C_OP_HALT) ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state, IR and latched flag only; strobes exist in EXEC.
  always_comb begin
    pc_incr      = 1'b0;
    pc_relbranch = 1'b0;
    reg_we       = 1'b0;
    alu_op       = 2'b00;
    if (state_q == S_EXEC) begin
      case (w_opcode)
        C_OP_LDI: begin
          reg_we  = 1'b1;
          alu_op  = 2'b00;
          pc_incr = 1'b1;
        end
        C_OP_ADD: begin
          reg_we  = 1'b1;
          alu_op  = 2'b01;
          pc_incr = 1'b1;
        end
        C_OP_SUB: begin
          reg_we  = 1'b1;
          alu_op  = 2'b10;
          pc_incr = 1'b1;
        end
        C_OP_BRZ: begin
          pc_relbranch = z_q;
          pc_incr      = ~z_q;
        end
        C_OP_BRA: begin
          pc_relbranch = 1'b1;
        end
        C_OP_NOP, C_OP_RSV, C_OP_HALT: begin
          pc_incr = 1'b1;
        end
        default: pc_incr = 1'b1;
      endcase
    end
  end

  // The branch offset is PSIZE wide, so taking the low PSIZE field bits
  // already yields the sign-extended two's-complement value.
  assign branch_addr = w_field[PSIZE-1:0];
  assign imm         = w_field;
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC);
  assign halted      = (state_q == S_HALTED);
  assign icount      = icount_q;

endmodule
`default_nettype wire
